// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - IF/ID/EX/WB pipeline sequencing controller
// Optional PIPE_PERF_CNT_EN adds saturating stall and retire counters.
module pipe_stage_ctrl #(
  parameter int REG_ADDR_W = 3,
  parameter int MUL_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_wr_en,
  input  logic                  ex_multi,
  input  logic                  ex_branch_taken,
  output logic                  instr_fetch,
  output logic                  decode,
  output logic                  execute,
  output logic                  write_back,
  output logic                  pc_en,
  output logic                  pc_load,
  output logic                  stall,
  output logic                  flush,
  output logic                  busy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [15:0]           perf_stall_cnt,
  output logic [15:0]           perf_retire_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

  state_t     state_q, state_d;
  logic       v_if_q, v_if_d;
  logic       v_id_q, v_id_d;
  logic       v_ex_q, v_ex_d;
  logic       v_wb_q, v_wb_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;

  logic       rs1_hit, rs2_hit;
  logic       hazard;
  logic       ex_hold;
  logic       branch_ok;
  logic       stall_c;
  logic       run_fetch;
  logic       fetch_en;
  logic       start_run;
  logic       pipe_empty;

  always_comb begin
    rs1_hit    = id_rs_used[0] & (id_rs1 == ex_rd);
    rs2_hit    = id_rs_used[1] & (id_rs2 == ex_rd);
    hazard     = v_id_q & v_ex_q & ex_wr_en & (ex_rd != '0) & (rs1_hit | rs2_hit);
    // cnt == 1 marks the final EX cycle of a multi-cycle op
    ex_hold    = v_ex_q & ex_multi & (cnt_q != 4'd1);
    branch_ok  = v_ex_q & ex_branch_taken & ~ex_hold;
    stall_c    = (hazard | ex_hold) & ~branch_ok;
    run_fetch  = (state_q == ST_RUN) & ~halt;
    start_run  = (state_q == ST_IDLE) & start;
    fetch_en   = run_fetch | start_run;
    pipe_empty = ~(v_if_q | v_id_q | v_ex_q | v_wb_q);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (v_ex_q && ex_multi && (cnt_q == 4'd0)) begin
      cnt_d = CNT_LOAD;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_comb begin
    v_if_d = v_if_q;
    v_id_d = v_id_q;
    v_ex_d = v_ex_q;
    v_wb_d = v_wb_q;
    if (branch_ok) begin
      v_if_d = fetch_en;
      v_id_d = 1'b0;
      v_ex_d = 1'b0;
      v_wb_d = 1'b1;
    end else if (ex_hold) begin
      v_wb_d = 1'b0;
    end else if (hazard) begin
      v_ex_d = 1'b0;
      v_wb_d = v_ex_q;
    end else begin
      v_wb_d = v_ex_q;
      v_ex_d = v_id_q;
      v_id_d = v_if_q;
      v_if_d = fetch_en;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (halt) state_d = ST_DRAIN;
      ST_DRAIN: if (pipe_empty) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      v_if_q  <= 1'b0;
      v_id_q  <= 1'b0;
      v_ex_q  <= 1'b0;
      v_wb_q  <= 1'b0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_if_q  <= v_if_d;
      v_id_q  <= v_id_d;
      v_ex_q  <= v_ex_d;
      v_wb_q  <= v_wb_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign instr_fetch = v_if_q;
  assign decode      = v_id_q;
  assign execute     = v_ex_q;
  assign write_back  = v_wb_q;
  assign pc_en       = v_if_q & ~stall_c & ~branch_ok & run_fetch;
  assign pc_load     = branch_ok;
  assign flush       = branch_ok;
  assign stall       = stall_c;
  assign busy        = busy_q;

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_retire_q, perf_retire_d;

  always_comb begin
    perf_stall_d  = perf_stall_q;
    perf_retire_d = perf_retire_q;
    if (start_run) begin
      perf_stall_d  = 16'd0;
      perf_retire_d = 16'd0;
    end else begin
      if (stall_c && (perf_stall_q != 16'hFFFF)) perf_stall_d = perf_stall_q + 16'd1;
      if (v_wb_q && (perf_retire_q != 16'hFFFF)) perf_retire_d = perf_retire_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q  <= 16'd0;
      perf_retire_q <= 16'd0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_retire_q <= perf_retire_d;
    end
  end

  assign perf_stall_cnt  = perf_stall_q;
  assign perf_retire_cnt = perf_retire_q;
`endif

endmodule
